dispatch_queue: RTL and testbench

Circular FIFO between decode and dispatch in the out-of-order core. It buffers decoded instructions and their PCs and presents the oldest one to the instruction router. It pops the head only in a cycle where the router does not stall. A `flush` from the branch unit empties the queue so wrong-path instructions never reach a reservation station.

---
 rtl/dispatch_queue_if.sv | 31 +++
 rtl/dispatch_queue.sv | 74 +++++++
 tb/tb_dispatch_queue.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dispatch_queue_if.sv
// Decode/dispatch side bundle of the dispatch queue: enqueue handshake, head
// entry presentation, router stall, flush and occupancy.
interface dispatch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
);
    logic                     flush;
    logic                     enq_valid;
    logic                     enq_ready;
    logic [XLEN-1:0]          enq_instruction;
    logic [XLEN-1:0]          enq_pc;
    logic [1:0]               enq_instruction_type;
    logic                     deq_valid;
    logic [XLEN-1:0]          deq_instruction;
    logic [XLEN-1:0]          deq_pc;
    logic [1:0]               deq_instruction_type;
    logic                     dispatch_stall;
    logic [$clog2(DEPTH):0]   count;

    // Decode and router side.
    modport master (
        output flush, enq_valid, enq_instruction, enq_pc, enq_instruction_type, dispatch_stall,
        input  enq_ready, deq_valid, deq_instruction, deq_pc, deq_instruction_type, count
    );

    // Queue side.
    modport slave (
        input  flush, enq_valid, enq_instruction, enq_pc, enq_instruction_type, dispatch_stall,
        output enq_ready, deq_valid, deq_instruction, deq_pc, deq_instruction_type, count
    );
endinterface

// File: rtl/dispatch_queue.sv
// Circular FIFO between decode and dispatch; presents the oldest decoded
// instruction to the router and empties instantly on a branch-unit flush.
module dispatch_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    dispatch_queue_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] r_instr [DEPTH];
    logic [XLEN-1:0] r_pc    [DEPTH];
    logic [1:0]      r_type  [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Handshake: an entry moves on an edge where valid and ready are both high.
    // Enqueue ready is ~full from registered count only; dequeue "ready" is
    // ~dispatch_stall. Flush overrides both transfers in its cycle.
    assign w_push = bus.enq_valid & ~w_full & ~bus.flush;
    assign w_pop  = ~w_empty & ~bus.dispatch_stall & ~bus.flush;

    assign bus.enq_ready            = ~w_full;
    assign bus.deq_valid            = ~w_empty;
    assign bus.deq_instruction      = r_instr[r_head];
    assign bus.deq_pc               = r_pc[r_head];
    assign bus.deq_instruction_type = r_type[r_head];
    assign bus.count                = r_count;

    // Entry storage carries no reset; validity comes solely from count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_tail] <= bus.enq_instruction;
            r_pc[r_tail]    <= bus.enq_pc;
            r_type[r_tail]  <= bus.enq_instruction_type;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue: push/drain, full boundary, wrap-around,
// flush priority and asynchronous reset, with a queue of expected head PCs.
module tb_dispatch_queue;
    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;
    logic [31:0] exp_q[$];

    dispatch_queue_if #(.XLEN(32), .DEPTH(8)) bus ();

    dispatch_queue #(.XLEN(32), .DEPTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [31:0] pc, input logic [1:0] ty,
                         input logic st, input logic fl);
        bus.enq_valid            = en;
        bus.enq_pc               = pc;
        bus.enq_instruction      = pc ^ 32'hA5A5_0000;
        bus.enq_instruction_type = ty;
        bus.dispatch_stall       = st;
        bus.flush                = fl;
    endtask

    // Pushes one entry with the router stalled, so nothing pops.
    task automatic push_stalled(input logic [31:0] pc, input logic [1:0] ty);
        drive(1'b1, pc, ty, 1'b1, 1'b0);
        tick();
        exp_q.push_back(pc);
    endtask

    // Pops every expected entry in order, then checks the queue is empty.
    task automatic drain(input string tag);
        logic [31:0] pc;
        drive(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            pc = exp_q.pop_front();
            chk({tag, "_valid"}, bus.deq_valid, 1'b1);
            chk({tag, "_pc"}, bus.deq_pc, pc);
            tick();
        end
        chk({tag, "_empty_valid"}, bus.deq_valid, 1'b0);
        chk({tag, "_empty_count"}, bus.count, 4'd0);
    endtask

    initial begin
        logic [31:0] pc;
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        drive(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);

        // Reset state
        #12;
        chk("rst_deq_valid", bus.deq_valid, 1'b0);
        chk("rst_enq_ready", bus.enq_ready, 1'b1);
        chk("rst_count", bus.count, 4'd0);
        #5 reset_n = 1'b1;
        tick();

        // Push three entries, then drain in order
        push_stalled(32'h0, 2'b00);
        chk("p1_count", bus.count, 4'd1);
        chk("p1_pc_visible", bus.deq_pc, 32'h0);
        push_stalled(32'h4, 2'b01);
        chk("p2_count", bus.count, 4'd2);
        push_stalled(32'h8, 2'b10);
        chk("p3_count", bus.count, 4'd3);
        chk("p3_head_type", bus.deq_instruction_type, 2'b00);
        chk("p3_head_instr", bus.deq_instruction, 32'hA5A5_0000);
        drive(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
        tick();
        chk("d1_pc", bus.deq_pc, 32'h4);
        chk("d1_type", bus.deq_instruction_type, 2'b01);
        chk("d1_count", bus.count, 4'd2);
        tick();
        chk("d2_pc", bus.deq_pc, 32'h8);
        chk("d2_type", bus.deq_instruction_type, 2'b10);
        chk("d2_instr", bus.deq_instruction, 32'hA5A5_0008);
        chk("d2_count", bus.count, 4'd1);
        tick();
        chk("d3_valid", bus.deq_valid, 1'b0);
        chk("d3_count", bus.count, 4'd0);
        exp_q.delete();

        // Fill while stalled; ninth push ignored
        for (int i = 0; i < 8; i++) begin
            push_stalled(32'h100 + 32'(4 * i), 2'(i));
        end
        chk("full_count", bus.count, 4'd8);
        chk("full_enq_ready", bus.enq_ready, 1'b0);
        drive(1'b1, 32'h999, 2'b11, 1'b1, 1'b0);
        tick();
        chk("ninth_count", bus.count, 4'd8);
        drive(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
        tick();
        void'(exp_q.pop_front());
        chk("release_count", bus.count, 4'd7);
        chk("release_enq_ready", bus.enq_ready, 1'b1);
        chk("release_head", bus.deq_pc, 32'h104);

        // Full boundary: push and pop while full stores nothing
        push_stalled(32'h120, 2'b00);
        chk("refull_count", bus.count, 4'd8);
        drive(1'b1, 32'hBAD, 2'b11, 1'b0, 1'b0);
        tick();
        void'(exp_q.pop_front());
        chk("fullpp_count", bus.count, 4'd7);
        chk("fullpp_head", bus.deq_pc, 32'h108);
        drain("full_drain");

        // Wrap-around at steady count of two
        push_stalled(32'h200, 2'b00);
        push_stalled(32'h204, 2'b01);
        for (int i = 0; i < 20; i++) begin
            pc = 32'h208 + 32'(4 * i);
            chk("wrap_count", bus.count, 4'd2);
            chk("wrap_pc", bus.deq_pc, exp_q[0]);
            drive(1'b1, pc, 2'(i), 1'b0, 1'b0);
            tick();
            void'(exp_q.pop_front());
            exp_q.push_back(pc);
        end
        drain("wrap_drain");

        // Flush beats a simultaneous push and pop
        for (int i = 0; i < 5; i++) begin
            push_stalled(32'h300 + 32'(4 * i), 2'b10);
        end
        chk("preflush_count", bus.count, 4'd5);
        drive(1'b1, 32'h3FF, 2'b01, 1'b0, 1'b1);
        tick();
        exp_q.delete();
        chk("flush_count", bus.count, 4'd0);
        chk("flush_deq_valid", bus.deq_valid, 1'b0);
        chk("flush_enq_ready", bus.enq_ready, 1'b1);
        push_stalled(32'h400, 2'b11);
        chk("postflush_count", bus.count, 4'd1);
        chk("postflush_pc", bus.deq_pc, 32'h400);
        chk("postflush_type", bus.deq_instruction_type, 2'b11);
        drain("flush_drain");

        // Asynchronous reset between edges
        for (int i = 0; i < 4; i++) begin
            push_stalled(32'h500 + 32'(4 * i), 2'b00);
        end
        chk("prereset_count", bus.count, 4'd4);
        #2 reset_n = 1'b0;
        #1;
        chk("areset_deq_valid", bus.deq_valid, 1'b0);
        chk("areset_count", bus.count, 4'd0);
        chk("areset_enq_ready", bus.enq_ready, 1'b1);
        exp_q.delete();
        #2 reset_n = 1'b1;
        push_stalled(32'h600, 2'b01);
        chk("postreset_count", bus.count, 4'd1);
        chk("postreset_pc", bus.deq_pc, 32'h600);
        drain("reset_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
